// File: rtl/mem_pkg.sv
// Shared types for the data memory controller: access sizes and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/byte-enable generation, load lane
// select with sign/zero extension, and alignment/size error flag.
module lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rword,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              align_err
);

  localparam int NB = XLEN / 8;

  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [XLEN-1:0] lane;

  always_comb begin
    byte_sh   = {addr_lo, 3'b000};
    half_sh   = {addr_lo[1], 4'b0000};
    lane      = rword >> byte_sh;
    wdata_sh  = '0;
    be        = '0;
    rdata_ext = '0;
    align_err = 1'b0;
    case (size)
      MEM_B: begin
        wdata_sh  = {{(XLEN-8){1'b0}}, wdata[7:0]} << byte_sh;
        be        = NB'(1) << addr_lo;
        rdata_ext = {{(XLEN-8){lane[7] & ~is_unsigned}}, lane[7:0]};
      end
      MEM_H: begin
        align_err = addr_lo[0];
        wdata_sh  = {{(XLEN-16){1'b0}}, wdata[15:0]} << half_sh;
        be        = NB'(3) << {addr_lo[1], 1'b0};
        rdata_ext = {{(XLEN-16){lane[15] & ~is_unsigned}}, lane[15:0]};
      end
      MEM_W: begin
        align_err = (addr_lo != 2'b00);
        wdata_sh  = wdata;
        be        = '1;
        rdata_ext = rword;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request/response handshake, programmable access
// latency and byte/half/word loads and stores.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e state, state_nxt;

  logic [CW-1:0]   cnt;
  logic            q_we;
  logic            q_unsigned;
  logic [1:0]      q_size;
  logic [XLEN-1:0] q_addr;
  logic [XLEN-1:0] q_wdata;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [XLEN-1:0] rword;
  logic [XLEN-1:0] wdata_sh;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] rdata_ext;
  logic            align_err;
  logic            range_err;
  logic            err;
  logic            access;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo     (q_addr[1:0]),
    .size        (q_size),
    .is_unsigned (q_unsigned),
    .wdata       (q_wdata),
    .rword       (rword),
    .wdata_sh    (wdata_sh),
    .be          (be),
    .rdata_ext   (rdata_ext),
    .align_err   (align_err)
  );

  // Full upper-address compare so out-of-range requests never alias onto the array.
  assign range_err = (q_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));
  assign err       = align_err | range_err;
  assign idx       = q_addr[2 +: AW];
  assign rword     = mem[idx];
  assign access    = (state == BUSY) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= 2'b00;
      q_addr     <= '0;
      q_wdata    <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cnt        <= CW'(LATENCY - 1);
        q_we       <= req_we;
        q_unsigned <= req_unsigned;
        q_size     <= req_size;
        q_addr     <= req_addr;
        q_wdata    <= req_wdata;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_rdata <= (err || q_we) ? '0 : rdata_ext;
        rsp_err   <= err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array contents deliberately have no reset; reset holds state in IDLE so no write can occur.
  always_ff @(posedge clk) begin
    if (access && q_we && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
